rd_req_sequencer: RTL and testbench
===================================

Name: rd_req_sequencer

Overview:
- Upstream driver of the `rd`/`addr` read bus that our temporal assertions check.
- Accepts read addresses over a valid/ready port and buffers them in a small FIFO.
- Replays each entry as an `rd` pulse of exactly HOLD_CYCLES clocks, with `addr` held stable for the whole pulse.
- Inserts exactly GAP_CYCLES low cycles between consecutive pulses, so the downstream `$rose(rd) |=> $stable(addr)` checks always hold.

Parameters:
- ADDR_W, 8, width of request and bus address.
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- HOLD_CYCLES, 2, clocks `rd` stays high per read; at least 1.
- GAP_CYCLES, 1, minimum clocks `rd` stays low between reads; at least 1.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_addr  in  ADDR_W  request address.
- req_ready  out  1  FIFO can accept a request; equals !full.
- rd  out  1  registered read strobe.
- addr  out  ADDR_W  registered read address.
- rd_done  out  1  one-cycle pulse in the cycle after `rd` falls.
- busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset state (rst_n low, takes effect asynchronously): rd=0, addr=0, rd_done=0, FIFO empty, level=0, req_ready=1, busy=0, FSM=IDLE. Reset mid-pulse drops `rd` immediately and discards all queued entries.
- Push: on a posedge where req_valid && req_ready, req_addr is written at the write pointer.
- No pass-through: req_ready is derived from registered occupancy, so a pop does not raise req_ready in the same cycle.
- Pointers: wrap modulo DEPTH; full when level==DEPTH.
- Push and pop on the same edge: level is unchanged.
- FSM states are IDLE, HOLD, GAP.
- IDLE:
  - If the FIFO is non-empty at a posedge: pop, addr<=head, rd<=1, cnt<=HOLD_CYCLES-1, go to HOLD.
  - Latency: a request pushed at edge N into an idle, empty block gives rd=1 from edge N+1.
- HOLD:
  - If cnt!=0: cnt decrements; rd and addr stay unchanged.
  - If cnt==0: rd<=0, rd_done<=1 for one cycle, cnt<=GAP_CYCLES-1, go to GAP.
  - `addr` keeps its value after `rd` falls; it is never cleared except by reset.
- GAP:
  - If cnt!=0: cnt decrements.
  - If cnt==0 and the FIFO is non-empty: pop and issue directly (same actions as IDLE), so `rd` is low for exactly GAP_CYCLES between back-to-back reads.
  - If cnt==0 and the FIFO is empty: go to IDLE.
- `addr` changes only on an edge where `rd` goes 0→1.
- `rd` high time is always exactly HOLD_CYCLES.
- req_valid while full: the request is not accepted; the source must hold it, per valid/ready rules.

Optional Feature:
- Macro: RD_REQ_SEQUENCER_SVA_EN.
- When defined, embedded concurrent assertions are compiled in:
  - `$rose(rd)` implies `addr` stable for HOLD_CYCLES-1 following clocks.
  - `rd` high for exactly HOLD_CYCLES.
  - `rd` low for at least GAP_CYCLES between pulses.
  - No push when full.
  - rd_done is a single-cycle pulse.
  - Each assertion reports pass with $info and fail with $error, including $time.
- When not defined: no assertion code exists; RTL behaviour is identical.

Decomposition:
- Package rd_seq_pkg holds:
  - the FSM state typedef (IDLE, HOLD, GAP);
  - default parameter constants;
  - the helper function for occupancy width (clog2(DEPTH)+1).
- One sub-module, rd_seq_fifo: a synchronous FIFO parameterised by ADDR_W and DEPTH, with push/pop/full/empty/level outputs.
- The top level holds the FSM, hold/gap counter and output registers.

Test Plan:
- Reset hold, then release; single push of addr=0x02 at edge 1 → rd=1, addr=0x02 at edges 2–3; rd=0 at edge 4; rd_done=1 for one cycle; busy falls after GAP.
- Push 0x04, 0x07, 0x09 back-to-back → three rd pulses of 2 clocks each, separated by exactly 1 low clock; addr values in order; addr never changes while rd=1.
- Push 5 entries with DEPTH=4 while the block is busy → req_ready low after the 4th accepted; the 5th is held, accepted once a pop occurs; all 5 are issued in order with no loss.
- HOLD_CYCLES=3, GAP_CYCLES=2, push 0xAA and 0x55 → rd high 3 clocks, low 2 clocks, high 3 clocks; addr 0xAA then 0x55.
- Assert rst_n low mid-HOLD with 2 entries queued → rd, addr, level go to 0 immediately; after release no pulse occurs until a new push.
- With RD_REQ_SEQUENCER_SVA_EN defined, run all scenarios above → zero $error reports; force-corrupt addr during rd in a fault-injection run → stability assertion fires.

Source files
------------

// File: rtl/rd_seq_pkg.sv
// Shared types and defaults for the read-request sequencer and its FIFO.
package rd_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam int DEF_ADDR_W      = 8;
    localparam int DEF_DEPTH       = 4;
    localparam int DEF_HOLD_CYCLES = 2;
    localparam int DEF_GAP_CYCLES  = 1;

    // Bits needed to count 0..n inclusive (n a power of 2).
    function automatic int occ_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/rd_seq_fifo.sv
// Synchronous FIFO, head visible combinationally; push ignored when full, pop ignored when empty.
// Occupancy is registered, so a pop frees space only from the following cycle.
module rd_seq_fifo
    import rd_seq_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push_i,
    input  logic [ADDR_W-1:0]         push_dat_i,
    input  logic                      pop_i,
    output logic [ADDR_W-1:0]         head_dat_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [occ_w(DEPTH)-1:0]   level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = occ_w(DEPTH);

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              push;
    logic              pop;

    assign full_o     = (level_q == LVL_W'(DEPTH));
    assign empty_o    = (level_q == '0);
    assign level_o    = level_q;
    assign head_dat_o = mem_q[rd_ptr_q];
    assign push       = push_i && !full_o;
    assign pop        = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: entries are only read once counted in level_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/rd_req_sequencer.sv
// Replays queued read addresses as rd pulses of HOLD_CYCLES clocks separated by GAP_CYCLES low clocks; rd rises one edge after a push into an idle block.
// req_ready = !full of the registered FIFO level; RD_REQ_SEQUENCER_SVA_EN compiles in bus-protocol assertions.
module rd_req_sequencer
    import rd_seq_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    input  logic [ADDR_W-1:0]         req_addr,
    output logic                      req_ready,
    output logic                      rd,
    output logic [ADDR_W-1:0]         addr,
    output logic                      rd_done,
    output logic                      busy,
    output logic [occ_w(DEPTH)-1:0]   level
);

    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = occ_w(CNT_MAX);
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rd_q, rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_done_q, rd_done_d;

    logic              fifo_full;
    logic              fifo_empty;
    logic [ADDR_W-1:0] fifo_head;
    logic              push;
    logic              pop;
    logic              issue;

    assign req_ready = !fifo_full;
    assign push      = req_valid && req_ready;

    rd_seq_fifo #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_dat_i (req_addr),
        .pop_i      (pop),
        .head_dat_o (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .level_o    (level)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        addr_d    = addr_q;
        rd_done_d = 1'b0;
        issue     = 1'b0;
        case (state_q)
            IDLE: begin
                issue = !fifo_empty;
            end
            HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    rd_d      = 1'b0;
                    rd_done_d = 1'b1;
                    cnt_d     = GAP_LD;
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!fifo_empty) begin
                    issue = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // addr only ever moves on the edge where rd rises.
        if (issue) begin
            addr_d  = fifo_head;
            rd_d    = 1'b1;
            cnt_d   = HOLD_LD;
            state_d = HOLD;
        end
        pop = issue;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rd_q      <= 1'b0;
            addr_q    <= '0;
            rd_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            addr_q    <= addr_d;
            rd_done_q <= rd_done_d;
        end
    end

    assign rd      = rd_q;
    assign addr    = addr_q;
    assign rd_done = rd_done_q;
    assign busy    = (state_q != IDLE) || !fifo_empty;

`ifdef RD_REQ_SEQUENCER_SVA_EN
    if (HOLD_CYCLES > 1) begin : g_addr_stable
        a_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
            $rose(rd) |=> $stable(addr) [*HOLD_CYCLES-1])
            $info("%0t a_addr_stable pass", $time);
        else
            $error("%0t a_addr_stable fail", $time);
    end

    a_rd_hold: assert property (@(posedge clk) disable iff (!rst_n)
        $rose(rd) |-> rd [*HOLD_CYCLES] ##1 !rd)
        $info("%0t a_rd_hold pass", $time);
    else
        $error("%0t a_rd_hold fail", $time);

    a_rd_gap: assert property (@(posedge clk) disable iff (!rst_n)
        $fell(rd) |-> !rd [*GAP_CYCLES])
        $info("%0t a_rd_gap pass", $time);
    else
        $error("%0t a_rd_gap fail", $time);

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_full |-> !push)
        $info("%0t a_no_push_full pass", $time);
    else
        $error("%0t a_no_push_full fail", $time);

    a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        rd_done |=> !rd_done)
        $info("%0t a_done_pulse pass", $time);
    else
        $error("%0t a_done_pulse fail", $time);
`endif

endmodule

// File: tb/tb_rd_req_sequencer.sv
// Directed bench: default instance plus a HOLD=3/GAP=2 instance, expected values hand-derived.
module tb_rd_req_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, req_valid, req_ready, rd, rd_done, busy;
    logic [7:0] req_addr, addr;
    logic [2:0] level;

    logic       rst2_n, req2_valid, req2_ready, rd2, rd2_done, busy2;
    logic [7:0] req2_addr, addr2;
    logic [2:0] level2;

    int checks   = 0;
    int failures = 0;

    rd_req_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rd        (rd),
        .addr      (addr),
        .rd_done   (rd_done),
        .busy      (busy),
        .level     (level)
    );

    rd_req_sequencer #(
        .ADDR_W      (8),
        .DEPTH       (4),
        .HOLD_CYCLES (3),
        .GAP_CYCLES  (2)
    ) dut2 (
        .clk       (clk),
        .rst_n     (rst2_n),
        .req_valid (req2_valid),
        .req_addr  (req2_addr),
        .req_ready (req2_ready),
        .rd        (rd2),
        .addr      (addr2),
        .rd_done   (rd2_done),
        .busy      (busy2),
        .level     (level2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scenario tables, index k = state sampled just after the (k+1)th edge.
    logic [7:0] s2_push [0:2]  = '{8'h04, 8'h07, 8'h09};
    logic       s2_rd   [0:10] = '{0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 0};
    logic [7:0] s2_addr [0:10] = '{8'h02, 8'h04, 8'h04, 8'h04, 8'h07, 8'h07,
                                   8'h07, 8'h09, 8'h09, 8'h09, 8'h09};
    logic       s2_done [0:10] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0};

    logic [7:0] s4_push [0:1]  = '{8'hAA, 8'h55};
    logic       s4_rd   [0:11] = '{0, 1, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0};
    logic [7:0] s4_addr [0:11] = '{8'h00, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA,
                                   8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55};
    logic       s4_done [0:11] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};

    logic [7:0] s3_order [0:3] = '{8'hA2, 8'hA3, 8'hA4, 8'hA5};

    initial begin
        #100000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       prev;
        int         hi, lo, n;
        logic [7:0] cur;

        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0;
        rst2_n = 1'b0; req2_valid = 1'b0; req2_addr = '0;
        #22;
        chk("reset rd", rd, 0);
        chk("reset addr", addr, 0);
        chk("reset rd_done", rd_done, 0);
        chk("reset level", level, 0);
        chk("reset req_ready", req_ready, 1);
        chk("reset busy", busy, 0);
        chk("reset rd2", rd2, 0);
        tick();
        rst_n = 1'b1; rst2_n = 1'b1;
        tick();

        // Single request: push at edge 1, rd high after edges 2-3, low after 4.
        req_valid = 1'b1; req_addr = 8'h02;
        tick();
        req_valid = 1'b0;
        chk("s1 level e1", level, 1);
        chk("s1 rd e1", rd, 0);
        chk("s1 busy e1", busy, 1);
        tick();
        chk("s1 rd e2", rd, 1);
        chk("s1 addr e2", addr, 8'h02);
        chk("s1 level e2", level, 0);
        tick();
        chk("s1 rd e3", rd, 1);
        chk("s1 addr e3", addr, 8'h02);
        tick();
        chk("s1 rd e4", rd, 0);
        chk("s1 rd_done e4", rd_done, 1);
        chk("s1 busy e4", busy, 1);
        chk("s1 addr kept e4", addr, 8'h02);
        tick();
        chk("s1 rd_done e5", rd_done, 0);
        chk("s1 busy e5", busy, 0);

        // Three back-to-back requests on the default instance.
        for (int k = 0; k < 11; k++) begin
            req_valid = (k < 3);
            req_addr  = (k < 3) ? s2_push[k] : 8'h00;
            tick();
            chk($sformatf("s2 rd c%0d", k), rd, s2_rd[k]);
            chk($sformatf("s2 addr c%0d", k), addr, s2_addr[k]);
            chk($sformatf("s2 rd_done c%0d", k), rd_done, s2_done[k]);
        end
        req_valid = 1'b0;
        chk("s2 busy end", busy, 0);

        // HOLD=3 / GAP=2 instance: 0xAA then 0x55.
        for (int k = 0; k < 12; k++) begin
            req2_valid = (k < 2);
            req2_addr  = (k < 2) ? s4_push[k] : 8'h00;
            tick();
            chk($sformatf("s4 rd c%0d", k), rd2, s4_rd[k]);
            chk($sformatf("s4 addr c%0d", k), addr2, s4_addr[k]);
            chk($sformatf("s4 rd_done c%0d", k), rd2_done, s4_done[k]);
        end
        req2_valid = 1'b0;
        chk("s4 busy end", busy2, 0);

        // Fill: leader 0xA0 keeps the block busy, then 0xA1..0xA5 against DEPTH=4.
        req2_valid = 1'b1; req2_addr = 8'hA0;
        tick();
        req2_addr = 8'hA1;
        tick();
        chk("s3 rd e2", rd2, 1);
        chk("s3 addr e2", addr2, 8'hA0);
        req2_addr = 8'hA2;
        tick();
        req2_addr = 8'hA3;
        tick();
        req2_addr = 8'hA4;
        tick();
        chk("s3 level full e5", level2, 4);
        chk("s3 ready low e5", req2_ready, 0);
        req2_addr = 8'hA5;
        tick();
        chk("s3 ready held e6", req2_ready, 0);
        chk("s3 level held e6", level2, 4);
        tick();
        chk("s3 ready after pop e7", req2_ready, 1);
        chk("s3 level after pop e7", level2, 3);
        chk("s3 rd e7", rd2, 1);
        chk("s3 addr e7", addr2, 8'hA1);
        tick();
        chk("s3 level A5 in e8", level2, 4);
        chk("s3 ready low e8", req2_ready, 0);
        req2_valid = 1'b0;

        prev = 1'b1; hi = 2; lo = 0; n = 0; cur = 8'hA1;
        for (int c = 0; c < 60; c++) begin
            if (!busy2) break;
            tick();
            if (rd2 && !prev) begin
                chk($sformatf("s3 gap before #%0d", n), lo, 2);
                chk($sformatf("s3 order #%0d", n), addr2, (n < 4) ? s3_order[n] : 8'hFF);
                cur = addr2;
                n++;
                hi = 1;
            end else if (rd2) begin
                chk($sformatf("s3 addr stable c%0d", c), addr2, cur);
                hi++;
            end else if (prev) begin
                chk($sformatf("s3 hold len c%0d", c), hi, 3);
                lo = 1;
            end else begin
                lo++;
            end
            prev = rd2;
        end
        chk("s3 busy drained", busy2, 0);
        chk("s3 issued count", n, 4);

        // Reset mid-HOLD with two entries still queued.
        req_valid = 1'b1; req_addr = 8'hB1;
        tick();
        req_addr = 8'hB2;
        tick();
        chk("s5 rd e2", rd, 1);
        chk("s5 addr e2", addr, 8'hB1);
        req_addr = 8'hB3;
        tick();
        req_valid = 1'b0;
        chk("s5 level e3", level, 2);
        chk("s5 rd e3", rd, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s5 async rd", rd, 0);
        chk("s5 async addr", addr, 0);
        chk("s5 async level", level, 0);
        chk("s5 async busy", busy, 0);
        chk("s5 async ready", req_ready, 1);
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("s5 quiet rd c%0d", c), rd, 0);
            chk($sformatf("s5 quiet level c%0d", c), level, 0);
        end
        req_valid = 1'b1; req_addr = 8'hC1;
        tick();
        req_valid = 1'b0;
        chk("s5 rd before issue", rd, 0);
        tick();
        chk("s5 rd new push", rd, 1);
        chk("s5 addr new push", addr, 8'hC1);
        tick();
        tick();
        tick();
        chk("s5 busy end", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
